// File: rtl/acpi_pkg.sv
// Shared definitions for the ACPI write-back stage.
//   ADDR_W / DATA_W : default pixel address and data widths (128x128 frame, 8-bit pixels)
//   CNT_W           : width of the completed-write counter
//   acpi_state_e    : frame sequencing states
//   acpi_entry_t    : one buffered pixel (address + data)
//   sat_inc         : saturating increment for the write counter
package acpi_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } acpi_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } acpi_entry_t;

  // Counter holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == {CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + CNT_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/acpi_wb_if.sv
// Bus bundle between the ACPI core, the write-back stage and frame memory.
//   core side   : acpi_valid, acpi_addr, acpi_data, finish
//   memory side : mem_wr_req, mem_wr_ack, mem_addr, mem_data
//   status      : full, overflow, pix_count, frame_done, order_err
// Modport slave is the write-back stage; master is whoever drives the core
// strobes and the memory acknowledge.
interface acpi_wb_if #(
  parameter int ADDR_W = acpi_pkg::ADDR_W,
  parameter int DATA_W = acpi_pkg::DATA_W
);

  logic                       acpi_valid;
  logic [ADDR_W-1:0]          acpi_addr;
  logic [DATA_W-1:0]          acpi_data;
  logic                       finish;
  logic                       mem_wr_req;
  logic                       mem_wr_ack;
  logic [ADDR_W-1:0]          mem_addr;
  logic [DATA_W-1:0]          mem_data;
  logic                       full;
  logic                       overflow;
  logic [acpi_pkg::CNT_W-1:0] pix_count;
  logic                       frame_done;
  logic                       order_err;

  modport slave (
    input  acpi_valid, acpi_addr, acpi_data, finish, mem_wr_ack,
    output mem_wr_req, mem_addr, mem_data, full, overflow, pix_count,
           frame_done, order_err
  );

  modport master (
    output acpi_valid, acpi_addr, acpi_data, finish, mem_wr_ack,
    input  mem_wr_req, mem_addr, mem_data, full, overflow, pix_count,
           frame_done, order_err
  );

endinterface

// File: rtl/acpi_sync_fifo.sv
// Generic synchronous FIFO.
//   clk, rst (async, active-high)
//   push/wr_data : write one entry; accepted when not full, or when full with a pop
//   pop/rd_data  : rd_data shows the head; pop removes it (ignored when empty)
//   full/empty   : registered, reflect occupancy after this cycle's push and pop
// DEPTH must be a power of two so the pointers wrap naturally.
module acpi_sync_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next_s;
  logic             full_r;
  logic             empty_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify push/pop and work out next occupancy.
  always_comb begin
    do_push_s = push && (!full_r || pop);
    do_pop_s  = pop && !empty_r;
    case ({do_push_s, do_pop_s})
      2'b10:   count_next_s = count_r + CNT_W'(1);
      2'b01:   count_next_s = count_r - CNT_W'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Pointers, occupancy and registered full/empty flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      count_r <= count_next_s;
      full_r  <= (count_next_s == CNT_W'(DEPTH));
      empty_r <= (count_next_s == CNT_W'(0));
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= wr_data;
  end

  assign rd_data = mem_r[rd_ptr_r];
  assign full    = full_r;
  assign empty   = empty_r;

endmodule

// File: rtl/acpi_wb.sv
// ACPI write-back stage: buffers interpolated pixels from the core, replays
// them to frame memory over a req/ack handshake and flags end of frame.
//   clk, rst (async, active-high)
//   bus (acpi_wb_if.slave):
//     acpi_valid/acpi_addr/acpi_data : pixel strobe from the core (no back-pressure)
//     finish                         : end-of-frame from the core, pulse or level
//     mem_wr_req/mem_addr/mem_data   : registered head slot toward memory
//     mem_wr_ack                     : memory accepts when high with mem_wr_req
//     full, overflow, pix_count, frame_done, order_err : status
// Optional build macro ACPI_WB_ORDER_CHECK_EN adds a strictly-increasing
// address check on accepted pixels; without it order_err is tied low.
module acpi_wb #(
  parameter int ADDR_W     = acpi_pkg::ADDR_W,
  parameter int DATA_W     = acpi_pkg::DATA_W,
  parameter int FIFO_DEPTH = 8
) (
  input logic       clk,
  input logic       rst,
  acpi_wb_if.slave  bus
);

  import acpi_pkg::*;

  localparam int ENTRY_W = ADDR_W + DATA_W;

  acpi_state_e       state_r;
  acpi_state_e       state_next_s;
  logic              finish_lat_r;
  logic              mem_wr_req_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_data_r;
  logic              overflow_r;
  logic [CNT_W-1:0]  pix_count_r;
  logic              frame_done_r;
  logic              order_err_s;

  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [ENTRY_W-1:0] fifo_rd_s;

  logic accept_s;
  logic slot_free_s;
  logic complete_s;
  logic pop_s;
  logic bypass_s;
  logic push_s;
  logic drop_s;

  // Datapath steering. An empty block loads the head slot straight from the
  // core so the request appears the next cycle; otherwise pixels queue in
  // the FIFO and refill the slot in the same cycle as each acknowledge.
  always_comb begin
    complete_s  = mem_wr_req_r && bus.mem_wr_ack;
    slot_free_s = !mem_wr_req_r || bus.mem_wr_ack;
    accept_s    = bus.acpi_valid && (state_r != DONE);
    pop_s       = slot_free_s && !fifo_empty_s;
    bypass_s    = accept_s && slot_free_s && fifo_empty_s;
    push_s      = accept_s && !bypass_s && (!fifo_full_s || pop_s);
    drop_s      = accept_s && !bypass_s && fifo_full_s && !pop_s;
  end

  acpi_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_s),
    .wr_data ({bus.acpi_addr, bus.acpi_data}),
    .pop     (pop_s),
    .rd_data (fifo_rd_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  // Frame sequencing; DRAIN also waits for a same-cycle strobe to land.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.acpi_valid) state_next_s = RUN;
        else                state_next_s = IDLE;
      end
      RUN: begin
        if (bus.finish || finish_lat_r) state_next_s = DRAIN;
        else                            state_next_s = RUN;
      end
      DRAIN: begin
        if (fifo_empty_s && !mem_wr_req_r && !accept_s) state_next_s = DONE;
        else                                            state_next_s = DRAIN;
      end
      DONE:    state_next_s = DONE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register and finish latch (a one-cycle finish pulse is remembered).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      finish_lat_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      finish_lat_r <= finish_lat_r | bus.finish;
    end
  end

  // Head slot: holds steady while memory stalls, refills on acknowledge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_wr_req_r <= 1'b0;
      mem_addr_r   <= {ADDR_W{1'b0}};
      mem_data_r   <= {DATA_W{1'b0}};
    end else if (pop_s) begin
      mem_wr_req_r             <= 1'b1;
      {mem_addr_r, mem_data_r} <= fifo_rd_s;
    end else if (bypass_s) begin
      mem_wr_req_r <= 1'b1;
      mem_addr_r   <= bus.acpi_addr;
      mem_data_r   <= bus.acpi_data;
    end else if (slot_free_s) begin
      mem_wr_req_r <= 1'b0;
    end
  end

  // Status flags and completed-write counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_r   <= 1'b0;
      pix_count_r  <= {CNT_W{1'b0}};
      frame_done_r <= 1'b0;
    end else begin
      overflow_r   <= overflow_r | drop_s;
      frame_done_r <= (state_next_s == DONE);
      if (complete_s) pix_count_r <= sat_inc(pix_count_r);
    end
  end

`ifdef ACPI_WB_ORDER_CHECK_EN
  logic [ADDR_W-1:0] last_addr_r;
  logic              have_last_r;
  logic              order_err_r;

  // Every stored pixel must have a strictly larger address than the one before.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_addr_r <= {ADDR_W{1'b0}};
      have_last_r <= 1'b0;
      order_err_r <= 1'b0;
    end else if (bypass_s || push_s) begin
      if (have_last_r && (bus.acpi_addr <= last_addr_r)) order_err_r <= 1'b1;
      last_addr_r <= bus.acpi_addr;
      have_last_r <= 1'b1;
    end
  end

  assign order_err_s = order_err_r;
`else
  assign order_err_s = 1'b0;
`endif

  assign bus.mem_wr_req = mem_wr_req_r;
  assign bus.mem_addr   = mem_addr_r;
  assign bus.mem_data   = mem_data_r;
  assign bus.full       = fifo_full_s;
  assign bus.overflow   = overflow_r;
  assign bus.pix_count  = pix_count_r;
  assign bus.frame_done = frame_done_r;
  assign bus.order_err  = order_err_s;

endmodule

// File: tb/tb_acpi_wb.sv
// Testbench for acpi_wb: directed sequences plus randomized frames. The
// reference model tracks the number of pixels held (slot + FIFO), the frame
// phase and the expected write order; a negedge monitor compares every
// status output and pops the scoreboard on each completed write.
module tb_acpi_wb;

  localparam int AW    = 14;
  localparam int DW    = 8;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  acpi_wb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  acpi_wb #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // reference model
  int             p;
  int             phase;
  bit             fin_lat;
  bit             m_ovf;
  int             m_cnt;
  bit             m_oe;
  logic [AW+DW-1:0] exp_q[$];
`ifdef ACPI_WB_ORDER_CHECK_EN
  bit             have_last;
  logic [AW-1:0]  last_addr;
`endif

  // expectations visible during the current cycle
  bit chk_en = 1'b0;
  bit e_req, e_full, e_ovf, e_done, e_oe;
  int e_cnt;

  bit            hold_prev = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus; model advances with the pixel-count rules.
  task automatic step(input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input bit ack, input bit fin);
    bit complete;
    bit acc;
    bus.acpi_valid = v;
    bus.acpi_addr  = a;
    bus.acpi_data  = d;
    bus.mem_wr_ack = ack;
    bus.finish     = fin;
    e_req  = (p > 0);
    e_full = (p == DEPTH + 1);
    e_ovf  = m_ovf;
    e_cnt  = m_cnt;
    e_done = (phase == 3);
    e_oe   = m_oe;
    complete = (p > 0) && ack;
    acc      = v && (phase != 3) && ((p < DEPTH + 1) || complete);
    if (acc) begin
      exp_q.push_back({a, d});
`ifdef ACPI_WB_ORDER_CHECK_EN
      if (have_last && (a <= last_addr)) m_oe = 1'b1;
      have_last = 1'b1;
      last_addr = a;
`endif
    end
    if (v && (phase != 3) && !acc) m_ovf = 1'b1;
    if (complete && (m_cnt < 16383)) m_cnt++;
    case (phase)
      0:       if (v) phase = 1;
      1:       if (fin || fin_lat) phase = 2;
      2:       if ((p == 0) && !v) phase = 3;
      default: phase = phase;
    endcase
    fin_lat = fin_lat | fin;
    p = p - int'(complete) + int'(acc);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    bus.acpi_valid = 1'b0;
    bus.acpi_addr  = '0;
    bus.acpi_data  = '0;
    bus.mem_wr_ack = 1'b0;
    bus.finish     = 1'b0;
    rst = 1'b1;
    #2;
    chk("rst_req",  bus.mem_wr_req, 0);
    chk("rst_addr", bus.mem_addr,   0);
    chk("rst_data", bus.mem_data,   0);
    chk("rst_full", bus.full,       0);
    chk("rst_ovf",  bus.overflow,   0);
    chk("rst_cnt",  bus.pix_count,  0);
    chk("rst_done", bus.frame_done, 0);
    chk("rst_oe",   bus.order_err,  0);
    p = 0; phase = 0; fin_lat = 0; m_ovf = 0; m_cnt = 0; m_oe = 0;
    exp_q.delete();
`ifdef ACPI_WB_ORDER_CHECK_EN
    have_last = 1'b0;
    last_addr = '0;
`endif
    e_req = 0; e_full = 0; e_ovf = 0; e_done = 0; e_oe = 0; e_cnt = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
  endtask

  // Pulse finish, then run until the model reaches DONE (bounded).
  task automatic drain(input bit rand_ack);
    int n;
    step(1'b0, '0, '0, rand_ack ? 1'($urandom) : 1'b1, 1'b1);
    n = 0;
    while (phase != 3 && n < 400) begin
      step(1'b0, '0, '0, rand_ack ? 1'($urandom) : 1'b1, 1'b0);
      n++;
    end
    step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("frame_done", bus.frame_done, 1);
    chk("sb_empty", exp_q.size(), 0);
  endtask

  // Monitor: status against model, head-slot stability, scoreboard on writes.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req",        bus.mem_wr_req, e_req);
      chk("full",       bus.full,       e_full);
      chk("overflow",   bus.overflow,   e_ovf);
      chk("pix_count",  bus.pix_count,  e_cnt);
      chk("frame_done", bus.frame_done, e_done);
      chk("order_err",  bus.order_err,  e_oe);
      if (hold_prev) begin
        chk("hold_addr", bus.mem_addr, prev_addr);
        chk("hold_data", bus.mem_data, prev_data);
      end
      if (bus.mem_wr_req && bus.mem_wr_ack) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          logic [AW+DW-1:0] e;
          e = exp_q.pop_front();
          chk("wr_addr", bus.mem_addr, e[AW+DW-1:DW]);
          chk("wr_data", bus.mem_data, e[DW-1:0]);
        end
      end
      hold_prev = bus.mem_wr_req && !bus.mem_wr_ack;
      prev_addr = bus.mem_addr;
      prev_data = bus.mem_data;
    end else begin
      hold_prev = 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    do_reset();

    // 1: ack tied high, five ordered pixels
    for (int i = 0; i < 5; i++) step(1'b1, AW'(2 * i + 1), DW'(10 + i), 1'b1, 1'b0);
    drain(1'b0);
    chk("t1_count", bus.pix_count, 5);
    chk("t1_ovf",   bus.overflow,  0);

    // 2: memory stalled while ten pixels arrive; tenth is dropped
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, AW'(100 + i), DW'($urandom), 1'b0, 1'b0);
    chk("t2_full", bus.full,     1);
    chk("t2_ovf",  bus.overflow, 1);
    drain(1'b0);
    chk("t2_count", bus.pix_count, 9);

    // 3: ack toggling during a burst
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, AW'(200 + i), DW'($urandom), (i % 2) == 0, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, '0, '0, (i % 2) == 0, 1'b0);
    drain(1'b0);
    chk("t3_count", bus.pix_count, 8);

    // 4: finish pulse with three pending, then a strobe after DONE
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, AW'(300 + i), DW'(i), 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
    chk("t4_not_done", bus.frame_done, 0);
    for (int i = 0; i < 5; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("t4_done", bus.frame_done, 1);
    step(1'b1, AW'(999), DW'(77), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("t4_count", bus.pix_count, 3);

    // 5: reset with four entries buffered
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, AW'(400 + i), DW'(i), 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b0, '0, '0, 1'b1, 1'b0);

    // 6: descending address pair
    do_reset();
    step(1'b1, AW'(129), DW'(1), 1'b1, 1'b0);
    step(1'b1, AW'(127), DW'(2), 1'b1, 1'b0);
    drain(1'b0);
    chk("t6_count", bus.pix_count, 2);
    chk("t6_oe",    bus.order_err, 32'(m_oe));

    // random frames
    for (int f = 0; f < 3; f++) begin
      do_reset();
      for (int i = 0; i < 150; i++)
        step(($urandom % 10) < 6, AW'($urandom), DW'($urandom), ($urandom % 10) < 5, 1'b0);
      drain(1'b1);
      chk("rand_count", bus.pix_count, 32'(m_cnt));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
